// File: rtl/wm_dispense_arbiter.sv
// wm_dispense_arbiter: round-robin arbiter for one shared water valve / soap pump.
// Each grant runs a timed water fill, a timed soap dose and a one-cycle DONE.
// All state changes happen on the falling edge of CLOCK. nRESET is asynchronous and active-low.
module wm_dispense_arbiter #(
  parameter int N          = 4,
  parameter int CW         = 5,
  parameter int REG_FILL   = 8,
  parameter int LRG_FILL   = 12,
  parameter int SOAP_TICKS = 3
) (
  input  logic         CLOCK,
  input  logic         nRESET,
  input  logic [N-1:0] REQ,
  input  logic [N-1:0] LARGE,
  output logic [N-1:0] GNT,
  output logic [N-1:0] DONE,
  output logic         WATER_ON,
  output logic         SOAP_ON,
  output logic         BUSY
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SOAP = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   g_q, g_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pick;
  logic            found;
  logic [N-1:0]    g_onehot;

  // Round-robin search: first asserted REQ at or above rr_ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < unsigned'(N); k++) begin
      idx = (32'(rr_q) + k) % unsigned'(N);
      if (!found && REQ[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // State, grant index, round-robin pointer and tick counter registers.
  always_ff @(negedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Load size is used only when the counter is loaded at grant,
  // so later changes to LARGE cannot affect the running fill.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = pick;
          rr_d    = (pick == PW'(N - 1)) ? '0 : pick + PW'(1);
          cnt_d   = LARGE[pick] ? CW'(LRG_FILL - 1) : CW'(REG_FILL - 1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (!REQ[g_q]) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cnt_d   = CW'(SOAP_TICKS - 1);
          state_d = SOAP;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      SOAP: begin
        if (!REQ[g_q]) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and grant index.
  always_comb begin
    g_onehot = N'(1) << g_q;
    GNT      = '0;
    DONE     = '0;
    WATER_ON = 1'b0;
    SOAP_ON  = 1'b0;
    BUSY     = 1'b0;
    case (state_q)
      FILL: begin
        GNT      = g_onehot;
        WATER_ON = 1'b1;
        BUSY     = 1'b1;
      end
      SOAP: begin
        GNT     = g_onehot;
        SOAP_ON = 1'b1;
        BUSY    = 1'b1;
      end
      ACK: begin
        GNT  = g_onehot;
        DONE = g_onehot;
        BUSY = 1'b1;
      end
      default: begin
        GNT = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wm_dispense_arbiter.sv
// Directed self-checking bench for wm_dispense_arbiter (N=4, fills 8/12, soap 3).
// DUT updates on negedge; outputs are sampled on posedge, inputs driven at posedge.
module tb_wm_dispense_arbiter;

  localparam int N = 4;
  localparam int REG = 8;
  localparam int LRG = 12;
  localparam int SOAPT = 3;

  logic         CLOCK;
  logic         nRESET;
  logic [N-1:0] REQ;
  logic [N-1:0] LARGE;
  logic [N-1:0] GNT;
  logic [N-1:0] DONE;
  logic         WATER_ON;
  logic         SOAP_ON;
  logic         BUSY;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  wm_dispense_arbiter #(
    .N(N), .CW(5), .REG_FILL(REG), .LRG_FILL(LRG), .SOAP_TICKS(SOAPT)
  ) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .REQ(REQ), .LARGE(LARGE),
    .GNT(GNT), .DONE(DONE), .WATER_ON(WATER_ON), .SOAP_ON(SOAP_ON), .BUSY(BUSY)
  );

  initial CLOCK = 1'b1;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_all_off(input string tag);
    chk({tag, "_gnt"},   32'(GNT), 0);
    chk({tag, "_done"},  32'(DONE), 0);
    chk({tag, "_water"}, 32'(WATER_ON), 0);
    chk({tag, "_soap"},  32'(SOAP_ON), 0);
    chk({tag, "_busy"},  32'(BUSY), 0);
  endtask

  task automatic idle_check();
    @(posedge CLOCK);
    chk_all_off("idle");
  endtask

  // Follows one service from its first FILL cycle; optionally toggles LARGE[g] at a
  // fill cycle, or drops REQ[g] at a given SOAP cycle and returns (abort).
  task automatic expect_service(input int unsigned g, input int unsigned fill,
                                input int unsigned toggle_at, input int unsigned abort_soap);
    logic [N-1:0] oh;
    oh = N'(1) << g;
    for (int unsigned i = 1; i <= fill; i++) begin
      @(posedge CLOCK);
      chk("fill_gnt",   32'(GNT), 32'(oh));
      chk("fill_water", 32'(WATER_ON), 1);
      chk("fill_soap",  32'(SOAP_ON), 0);
      chk("fill_done",  32'(DONE), 0);
      if (i == toggle_at) LARGE[g] = ~LARGE[g];
    end
    for (int unsigned j = 1; j <= unsigned'(SOAPT); j++) begin
      @(posedge CLOCK);
      chk("soap_gnt",   32'(GNT), 32'(oh));
      chk("soap_water", 32'(WATER_ON), 0);
      chk("soap_soap",  32'(SOAP_ON), 1);
      chk("soap_done",  32'(DONE), 0);
      if (j == abort_soap) begin
        REQ[g] = 1'b0;
        return;
      end
    end
    @(posedge CLOCK);
    chk("ack_gnt",   32'(GNT), 32'(oh));
    chk("ack_done",  32'(DONE), 32'(oh));
    chk("ack_water", 32'(WATER_ON), 0);
    chk("ack_soap",  32'(SOAP_ON), 0);
    chk("ack_busy",  32'(BUSY), 1);
  endtask

  initial begin
    nRESET = 1'b0;
    REQ    = '0;
    LARGE  = '0;

    phase = "reset";
    @(posedge CLOCK);
    chk_all_off("rst");
    nRESET = 1'b1;

    // Reset mid-FILL: outputs drop immediately, between clock edges.
    phase = "t1_reset_mid_fill";
    REQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK);
      chk("pre_gnt",   32'(GNT), 32'h1);
      chk("pre_water", 32'(WATER_ON), 1);
    end
    #2 nRESET = 1'b0;
    #1 chk_all_off("async");
    REQ = 4'b0011;
    @(posedge CLOCK);
    chk_all_off("held1");
    @(posedge CLOCK);
    chk_all_off("held2");
    nRESET = 1'b1;

    // rr_ptr back at 0: machine 0 first, regular loads.
    phase = "t2_regular";
    expect_service(0, REG, 0, 0);
    REQ[0] = 1'b0;
    idle_check();
    expect_service(1, REG, 0, 0);
    REQ[1] = 1'b0;
    idle_check();

    // Large load; LARGE toggled mid-fill must not change the fill length.
    phase = "t3_large";
    LARGE[2] = 1'b1;
    REQ[2]   = 1'b1;
    expect_service(2, LRG, 5, 0);
    REQ[2] = 1'b0;
    LARGE  = '0;
    idle_check();

    // All requesting from reset: order 0,1,2,3 with an IDLE cycle between.
    phase = "t4_all";
    nRESET = 1'b0;
    REQ    = 4'b1111;
    @(posedge CLOCK);
    chk_all_off("rst4");
    nRESET = 1'b1;
    for (int unsigned g = 0; g < 4; g++) begin
      expect_service(g, REG, 0, 0);
      REQ[g] = 1'b0;
      idle_check();
    end

    // Wrap: after serving 3, REQ=1001 serves 0 before 3.
    phase = "t5_wrap";
    REQ = 4'b1000;
    expect_service(3, REG, 0, 0);
    REQ[3] = 1'b0;
    idle_check();
    REQ = 4'b1001;
    expect_service(0, REG, 0, 0);
    REQ[0] = 1'b0;
    idle_check();
    expect_service(3, REG, 0, 0);
    REQ[3] = 1'b0;
    idle_check();

    // Abort in SOAP cycle 2: back to IDLE, no DONE, pending 2 served next.
    phase = "t6_abort";
    REQ = 4'b0110;
    expect_service(1, REG, 0, 2);
    @(posedge CLOCK);
    chk_all_off("abort");
    expect_service(2, REG, 0, 0);
    REQ[2] = 1'b0;
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
